alu_div_seq: RTL

Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU that borrows the ALU's shared adder0 one cycle at a time. It runs a 32-step restoring division with a local partial remainder and quotient, and does sign pre- and post-processing locally. The block sits beside the EX stage. The pipeline grants adder0 in cycles where EX has no ALU add/sub of its own.

---
 rtl/alu_div_seq_pkg.sv | 40 ++++
 rtl/alu_div_seq_rv_cond_neg.sv | 11 +
 rtl/alu_div_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_div_seq_pkg.sv
// Shared types for the multi-cycle divider that borrows ALU adder0.
//   adder_op_e  : adder0 operation select (the divider only ever uses ALU_SUB)
//   div_op_e    : RV32M divide/remainder flavour
//   div_state_e : sequencer states
//   DIV_STEPS   : number of restoring-division steps (one per quotient bit)
package alu_div_seq_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01
    } adder_op_e;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_e;

    localparam int DIV_STEPS = 32;

    // DIV and REM are the signed flavours (op[0] == 0).
    function automatic logic is_signed_op(input div_op_e op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder (op[1] == 1).
    function automatic logic is_rem_op(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_div_seq_rv_cond_neg.sv
// rv_cond_neg: 32-bit conditional two's-complement negate.
//   neg  : when high, dout = -din; otherwise dout = din
//   din  : operand
//   dout : result
module rv_cond_neg (
    input  logic        neg,
    input  logic [31:0] din,
    output logic [31:0] dout
);
    assign dout = neg ? (~din + 32'd1) : din;
endmodule

// File: rtl/alu_div_seq.sv
// alu_div_seq: RV32M DIV/DIVU/REM/REMU sequencer. Runs a 32-step restoring
// division, borrowing the ALU's adder0 for the trial subtract in each step.
// Sign handling is done locally with rv_cond_neg instances.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake (in_op, in_a, in_b)
//   flush                 : abort, back to IDLE next cycle
//   out_valid/out_ready   : result handshake (out_result)
//   alu_req/alu_gnt       : adder0 request and grant
//   alu_adder_en/op       : adder0 enable (== alu_req), op (always ALU_SUB)
//   alu_op_a/alu_op_b     : adder0 operands (0 when not requesting)
//   alu_adder_res         : adder0 result (combinational from the operands)
//   busy                  : sequencer not idle
// Optional feature: define DIV_ZERO_FAST_EN to short-circuit a zero divisor
// straight from PREP to DONE without using adder0.
module alu_div_seq
    import alu_div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  div_op_e     in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic        alu_adder_en,
    output adder_op_e   alu_adder_op,
    output logic [31:0] alu_op_a,
    output logic [31:0] alu_op_b,
    input  logic [31:0] alu_adder_res,
    output logic        busy
);
    localparam logic [5:0] CNT_LAST = 6'(DIV_STEPS - 1);

    div_state_e  state, state_nxt;
    div_op_e     op_q;
    logic        sa, sb;
    logic [31:0] a_q, b_q, r_q;
    logic [5:0]  cnt;

    logic        accept, b_zero, no_borrow, last_step;
    logic [31:0] step_a;
    logic [31:0] opn_in, opn_out, q_fix, r_fix;
    logic        opn_neg;

    assign accept    = (state == IDLE) && in_valid && !flush;
    assign b_zero    = (b_q == '0);
    // Shift the next dividend bit into the partial remainder; the bit that
    // falls off the top is an implicit 33rd bit of the trial subtract.
    assign step_a    = {r_q[30:0], a_q[31]};
    assign no_borrow = r_q[31] |
                       ~((~step_a[31] & b_q[31]) |
                         (~(step_a[31] ^ b_q[31]) & alu_adder_res[31]));
    assign last_step = alu_gnt && (cnt == CNT_LAST);

    // One operand negator used twice: on accept it conditions the divisor
    // straight from the input, in PREP it conditions the latched dividend.
    assign opn_in  = (state == IDLE) ? in_b : a_q;
    assign opn_neg = (state == IDLE) ? (in_b[31] & is_signed_op(in_op)) : sa;

    rv_cond_neg u_neg_op  (.neg(opn_neg),          .din(opn_in), .dout(opn_out));
    rv_cond_neg u_neg_quo (.neg((sa ^ sb) & ~b_zero), .din(a_q), .dout(q_fix));
    rv_cond_neg u_neg_rem (.neg(sa),               .din(r_q),    .dout(r_fix));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = PREP;
`ifdef DIV_ZERO_FAST_EN
            PREP: state_nxt = b_zero ? DONE : ITER;
`else
            PREP: state_nxt = ITER;
`endif
            ITER: if (last_step) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign in_ready     = (state == IDLE);
    assign busy         = (state != IDLE);
    assign out_valid    = (state == DONE);
    assign alu_req      = (state == ITER);
    assign alu_adder_en = alu_req;
    assign alu_adder_op = ALU_SUB;
    assign alu_op_a     = alu_req ? step_a : '0;
    assign alu_op_b     = alu_req ? b_q    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= DIV;
            sa         <= 1'b0;
            sb         <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            cnt        <= '0;
            out_result <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: if (accept) begin
                    op_q <= in_op;
                    sa   <= in_a[31] & is_signed_op(in_op);
                    sb   <= in_b[31] & is_signed_op(in_op);
                    a_q  <= in_a;
                    b_q  <= opn_out;
                end
                PREP: begin
                    a_q <= opn_out;
                    r_q <= '0;
                    cnt <= '0;
`ifdef DIV_ZERO_FAST_EN
                    // a_q still holds the raw dividend here.
                    if (b_zero) out_result <= is_rem_op(op_q) ? a_q : '1;
`endif
                end
                ITER: if (alu_gnt) begin
                    r_q <= no_borrow ? alu_adder_res : step_a;
                    a_q <= {a_q[30:0], no_borrow};
                    cnt <= cnt + 6'd1;
                end
                FIX: out_result <= is_rem_op(op_q) ? r_fix : q_fix;
                default: ;
            endcase
        end
    end

endmodule
